// File: rtl/bilinear_interp_pipe.sv
// bilinear_interp_pipe
//   Three-stage pipelined bilinear interpolator for the VGA upscaling path.
//   S1 lerps each source row horizontally by fx, S2 lerps the two row results
//   vertically by fy, S3 applies a single full-precision round/truncate and
//   registers the output pixel. Flow control is a global stall driven by the
//   output handshake.
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational from out_ready)
//   p_tl, p_tr, p_bl, p_br  2x2 source neighbourhood, channel NUM_CH-1 in the MSBs
//   fx, fy                sub-pixel phase; right/bottom weight = phase / 2^FRAC_W
//   out_valid / out_ready output handshake
//   out_data              interpolated pixel, held stable while stalled
module bilinear_interp_pipe #(
    parameter int unsigned CH_W   = 4,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned FRAC_W = 1,
    parameter int unsigned ROUND  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*CH_W-1:0]   p_tl,
    input  logic [NUM_CH*CH_W-1:0]   p_tr,
    input  logic [NUM_CH*CH_W-1:0]   p_bl,
    input  logic [NUM_CH*CH_W-1:0]   p_br,
    input  logic [FRAC_W-1:0]        fx,
    input  logic [FRAC_W-1:0]        fy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   out_data
);

    localparam int unsigned PW = NUM_CH * CH_W;
    localparam int unsigned TW = CH_W + FRAC_W;      // S1 row-lerp width
    localparam int unsigned AW = CH_W + 2 * FRAC_W;  // S2 accumulator width
    // N = 2^FRAC_W, needs one extra bit to hold the full weight.
    localparam logic [FRAC_W:0] NPH = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [AW-1:0] HALF = (ROUND != 0) ? (AW'(1) << (2 * FRAC_W - 1)) : '0;

    logic stall;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [FRAC_W-1:0]           fy1_q, fy1_d;
    logic [NUM_CH-1:0][TW-1:0]   top_q, top_d, bot_q, bot_d;
    logic [NUM_CH-1:0][AW-1:0]   acc_q, acc_d;
    logic [PW-1:0]               out_q, out_d;

    logic [FRAC_W:0] wx_l, wx_r, wy_t, wy_b;

    // S1: horizontal lerp. Products and sums fit in TW bits by construction.
    always_comb begin
        wx_l = NPH - {1'b0, fx};
        wx_r = {1'b0, fx};
        for (int c = 0; c < NUM_CH; c++) begin
            top_d[c] = TW'(p_tl[c*CH_W +: CH_W]) * TW'(wx_l)
                     + TW'(p_tr[c*CH_W +: CH_W]) * TW'(wx_r);
            bot_d[c] = TW'(p_bl[c*CH_W +: CH_W]) * TW'(wx_l)
                     + TW'(p_br[c*CH_W +: CH_W]) * TW'(wx_r);
        end
        fy1_d = fy;
        v1_d  = in_valid;
    end

    // S2: vertical lerp using the fy that travelled with the S1 data.
    always_comb begin
        wy_t = NPH - {1'b0, fy1_q};
        wy_b = {1'b0, fy1_q};
        for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = AW'(top_q[c]) * AW'(wy_t) + AW'(bot_q[c]) * AW'(wy_b);
        end
        v2_d = v1_q;
    end

    // S3: one rounding step on the full-precision result; cannot exceed 2^CH_W-1.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            out_d[c*CH_W +: CH_W] = CH_W'((acc_q[c] + HALF) >> (2 * FRAC_W));
        end
        v3_d = v2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            fy1_q <= '0;
            top_q <= '0;
            bot_q <= '0;
            acc_q <= '0;
            out_q <= '0;
        end else if (!stall) begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            fy1_q <= fy1_d;
            top_q <= top_d;
            bot_q <= bot_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    // Global stall: the whole pipe freezes while the output is blocked.
    always_comb begin
        stall     = v3_q & ~out_ready;
        in_ready  = ~stall;
        out_valid = v3_q;
        out_data  = out_q;
    end

endmodule

// File: tb/tb_bilinear_interp_pipe.sv
module tb_bilinear_interp_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [11:0] p_tl, p_tr, p_bl, p_br;
    logic        fx, fy;
    logic [1:0]  fx2, fy2;

    logic        in_ready, out_valid;
    logic [11:0] out_data;
    logic        in_ready_r, out_valid_r;
    logic [11:0] out_data_r;
    logic        in_ready_f2, out_valid_f2;
    logic [11:0] out_data_f2;

    int total = 0;
    int bad   = 0;

    bilinear_interp_pipe #(.CH_W(4), .NUM_CH(3), .FRAC_W(1), .ROUND(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .p_tl(p_tl), .p_tr(p_tr), .p_bl(p_bl), .p_br(p_br), .fx(fx), .fy(fy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    bilinear_interp_pipe #(.CH_W(4), .NUM_CH(3), .FRAC_W(1), .ROUND(1)) dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
        .p_tl(p_tl), .p_tr(p_tr), .p_bl(p_bl), .p_br(p_br), .fx(fx), .fy(fy),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r)
    );

    bilinear_interp_pipe #(.CH_W(4), .NUM_CH(3), .FRAC_W(2), .ROUND(0)) dut_f2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_f2),
        .p_tl(p_tl), .p_tr(p_tr), .p_bl(p_bl), .p_br(p_br), .fx(fx2), .fy(fy2),
        .out_valid(out_valid_f2), .out_ready(out_ready), .out_data(out_data_f2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: weighted sum of the four corners, one division at the end.
    function automatic logic [11:0] ref_pix(input logic [11:0] tl, input logic [11:0] tr,
                                            input logic [11:0] bl, input logic [11:0] br,
                                            input int fxv, input int fyv, input int fw,
                                            input int rnd);
        logic [11:0] r;
        int n, a, b, d, e, v;
        n = 1 << fw;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            a = int'(tl[c*4 +: 4]);
            b = int'(tr[c*4 +: 4]);
            d = int'(bl[c*4 +: 4]);
            e = int'(br[c*4 +: 4]);
            v = a * (n - fxv) * (n - fyv) + b * fxv * (n - fyv)
              + d * (n - fxv) * fyv + e * fxv * fyv;
            if (rnd != 0) v = v + (n * n) / 2;
            r[c*4 +: 4] = 4'(v / (n * n));
        end
        return r;
    endfunction

    // Sends one pixel into an idle pipe and waits for it at the output.
    task automatic run_one(input logic [11:0] tl, input logic [11:0] tr,
                           input logic [11:0] bl, input logic [11:0] br,
                           input logic fxa, input logic fya,
                           input logic [1:0] fxb, input logic [1:0] fyb,
                           output logic [11:0] o0, output logic [11:0] o1,
                           output logic [11:0] o2, output int lat);
        @(posedge clk); #1;
        p_tl = tl; p_tr = tr; p_bl = bl; p_br = br;
        fx = fxa; fy = fya; fx2 = fxb; fy2 = fyb;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        o0 = '0; o1 = '0; o2 = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                o0 = out_data; o1 = out_data_r; o2 = out_data_f2;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        p_tl = '0; p_tr = '0; p_bl = '0; p_br = '0;
        fx = 1'b0; fy = 1'b0; fx2 = '0; fy2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 12'h000) begin bad++; $display("FAIL reset_out_data: got %h want 000", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if ({out_valid_r, out_valid_f2, in_ready_r, in_ready_f2} !== 4'b0011) begin
            bad++; $display("FAIL reset_variants: got %b want 0011",
                            {out_valid_r, out_valid_f2, in_ready_r, in_ready_f2});
        end
    endtask

    task automatic test_identity();
        logic [11:0] o0, o1, o2;
        int lat;
        run_one(12'hABC, 12'($urandom), 12'($urandom), 12'($urandom), 1'b0, 1'b0, 2'd0, 2'd0,
                o0, o1, o2, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL identity_latency: got %0d want 3", lat); end
        total++; if (o0 !== 12'hABC) begin bad++; $display("FAIL identity_r0: got %h want abc", o0); end
        total++; if (o1 !== 12'hABC) begin bad++; $display("FAIL identity_r1: got %h want abc", o1); end
        total++; if (o2 !== 12'hABC) begin bad++; $display("FAIL identity_f2: got %h want abc", o2); end
    endtask

    task automatic test_horizontal();
        logic [11:0] o0, o1, o2;
        int lat;
        run_one(12'h000, 12'hFFF, 12'($urandom), 12'($urandom), 1'b1, 1'b0, 2'd1, 2'd0,
                o0, o1, o2, lat);
        total++; if (o0 !== 12'h777) begin bad++; $display("FAIL horiz_r0: got %h want 777", o0); end
        total++; if (o1 !== 12'h888) begin bad++; $display("FAIL horiz_r1: got %h want 888", o1); end
        total++; if (o2 !== 12'h333) begin bad++; $display("FAIL horiz_f2_fff: got %h want 333", o2); end
        run_one(12'h000, 12'hCCC, 12'($urandom), 12'($urandom), 1'b0, 1'b0, 2'd1, 2'd0,
                o0, o1, o2, lat);
        total++; if (o2 !== 12'h333) begin bad++; $display("FAIL horiz_f2_ccc: got %h want 333", o2); end
    endtask

    task automatic test_diagonal();
        logic [11:0] o0, o1, o2;
        int lat;
        run_one(12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 1'b1, 1'b1, 2'd2, 2'd2, o0, o1, o2, lat);
        total++; if (o0 !== 12'h777) begin bad++; $display("FAIL diag_r0: got %h want 777", o0); end
        total++; if (o1 !== 12'h888) begin bad++; $display("FAIL diag_r1: got %h want 888", o1); end
        total++; if (o2 !== 12'h777) begin bad++; $display("FAIL diag_f2: got %h want 777", o2); end
    endtask

    task automatic test_random();
        logic [11:0] tl, tr, bl, br, o0, o1, o2, e0, e1, e2;
        logic a, b;
        logic [1:0] c, d;
        int lat;
        for (int k = 0; k < 25; k++) begin
            tl = 12'($urandom); tr = 12'($urandom); bl = 12'($urandom); br = 12'($urandom);
            a = 1'($urandom); b = 1'($urandom); c = 2'($urandom); d = 2'($urandom);
            e0 = ref_pix(tl, tr, bl, br, int'(a), int'(b), 1, 0);
            e1 = ref_pix(tl, tr, bl, br, int'(a), int'(b), 1, 1);
            e2 = ref_pix(tl, tr, bl, br, int'(c), int'(d), 2, 0);
            run_one(tl, tr, bl, br, a, b, c, d, o0, o1, o2, lat);
            total++; if (o0 !== e0) begin bad++; $display("FAIL rand_r0[%0d]: got %h want %h", k, o0, e0); end
            total++; if (o1 !== e1) begin bad++; $display("FAIL rand_r1[%0d]: got %h want %h", k, o1, e1); end
            total++; if (o2 !== e2) begin bad++; $display("FAIL rand_f2[%0d]: got %h want %h", k, o2, e2); end
        end
    endtask

    // Streams n pixels; out_ready either follows a fixed low window (cycles 4-8) or is random.
    task automatic test_stream(input int n, input bit rand_ready);
        logic [11:0] exp_q[$];
        logic [11:0] held, e;
        int  sent, recv, stall_cnt;
        bit  stalled_prev, need_new;
        sent = 0; recv = 0; stall_cnt = 0; stalled_prev = 1'b0; need_new = 1'b1; held = '0;
        for (int cyc = 0; cyc < 300 && recv < n; cyc++) begin
            @(posedge clk); #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc <= 8);
            if (sent < n) begin
                if (need_new) begin
                    p_tl = rand_ready ? 12'($urandom) : 12'(sent * 12'h111);
                    p_tr = 12'($urandom); p_bl = 12'($urandom); p_br = 12'($urandom);
                    fx = 1'($urandom); fy = 1'($urandom); fx2 = 2'($urandom); fy2 = 2'($urandom);
                    need_new = 1'b0;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            total++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                bad++; $display("FAIL stream_in_ready cyc%0d: got %b want %b", cyc, in_ready,
                                !(out_valid && !out_ready));
            end
            if (stalled_prev) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    bad++; $display("FAIL stream_hold cyc%0d: got %b/%h want 1/%h", cyc,
                                    out_valid, out_data, held);
                end
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_pix(p_tl, p_tr, p_bl, p_br, int'(fx), int'(fy), 1, 0));
                sent++;
                need_new = 1'b1;
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stream_extra cyc%0d: got %h want none", cyc, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++; $display("FAIL stream_data[%0d]: got %h want %h", recv, out_data, e);
                    end
                end
                recv++;
            end
            stalled_prev = out_valid && !out_ready;
            held = out_data;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (recv !== n) begin bad++; $display("FAIL stream_count: got %0d want %0d", recv, n); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stream_left: got %0d want 0", exp_q.size()); end
        if (!rand_ready) begin
            total++; if (stall_cnt !== 5) begin bad++; $display("FAIL stream_stalls: got %0d want 5", stall_cnt); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [11:0] o0, o1, o2, e0;
        int lat;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            p_tl = 12'($urandom); p_tr = 12'($urandom); p_bl = 12'($urandom); p_br = 12'($urandom);
            fx = 1'($urandom); fy = 1'($urandom);
            in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 12'h000) begin bad++; $display("FAIL midreset_data: got %h want 000", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
        e0 = ref_pix(12'h5A3, 12'h1C7, 12'hE24, 12'h9B0, 1, 0, 1, 0);
        run_one(12'h5A3, 12'h1C7, 12'hE24, 12'h9B0, 1'b1, 1'b0, 2'd0, 2'd0, o0, o1, o2, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL midreset_latency: got %0d want 3", lat); end
        total++; if (o0 !== e0) begin bad++; $display("FAIL midreset_pixel: got %h want %h", o0, e0); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_horizontal();
        test_diagonal();
        test_random();
        test_stream(10, 1'b0);
        test_stream(40, 1'b1);
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
